// File: rtl/fir_perf_pkg.sv
// fir_perf_pkg: shared types and constants for the FIR performance monitor.
//   state_e      - run-tracking FSM states
//   OFF_*        - Wishbone register byte offsets inside the 32-byte window
//   MARK_*       - checkbits marker bytes driven on io_out
//   C_*          - indices into the monitor's counter bank
package fir_perf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [4:0] OFF_CTRL      = 5'h00;
    localparam logic [4:0] OFF_LAST_CYC  = 5'h04;
    localparam logic [4:0] OFF_TOTAL_CYC = 5'h08;
    localparam logic [4:0] OFF_RUN_CNT   = 5'h0C;
    localparam logic [4:0] OFF_FIRST_LAT = 5'h10;
    localparam logic [4:0] OFF_IN_BEATS  = 5'h14;
    localparam logic [4:0] OFF_OUT_BEATS = 5'h18;
    localparam logic [4:0] OFF_LAST_Y    = 5'h1C;

    localparam int CTRL_BUSY = 0;
    localparam int CTRL_OVR  = 1;
    localparam int CTRL_EN   = 2;

    localparam logic [7:0] MARK_START = 8'hA5;
    localparam logic [7:0] MARK_DONE  = 8'h5A;

    localparam int C_LAST  = 0;
    localparam int C_TOTAL = 1;
    localparam int C_RUNS  = 2;
    localparam int C_FIRST = 3;
    localparam int C_IN    = 4;
    localparam int C_OUT   = 5;
    localparam int NUM_CNT = 6;

endpackage

// File: rtl/fir_perf_monitor_if.sv
// fir_perf_monitor_if: Wishbone slave bus of the FIR performance monitor.
//   wbs_cyc_i/stb_i/we_i - cycle, strobe, write enable
//   wbs_sel_i            - byte selects
//   wbs_adr_i/dat_i      - address, write data
//   wbs_ack_o/dat_o      - acknowledge, read data
// master: bus initiator (firmware side); slave: the monitor.
interface fir_perf_monitor_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/fir_perf_sat_cnt.sv
// fir_perf_sat_cnt: CNT_W-bit saturating accumulator.
//   clk_i, rst_i - clock, synchronous active-high reset
//   clr_i        - clear to zero (wins over inc_i)
//   inc_i        - add add_i this cycle
//   add_i        - value added when inc_i is high
//   cnt_o        - current count; sticks at all-ones, never wraps
module fir_perf_sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] add_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   sum;

    always_comb begin
        // one extra bit catches the carry that would otherwise wrap
        sum   = {1'b0, cnt_q} + {1'b0, add_i};
        cnt_d = cnt_q;
        if (clr_i)      cnt_d = '0;
        else if (inc_i) cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fir_perf_monitor.sv
// fir_perf_monitor: latency/throughput timer around the FIR engine.
//   wb_clk_i, wb_rst_i   - clock, synchronous active-high reset
//   wbs                  - Wishbone slave (32-byte window at BASE_ADDR)
//   ap_start, ap_done    - FIR start (edge-detected) and done pulse
//   ss_tvalid/ss_tready  - input-stream handshake (counted as IN_BEATS)
//   sm_tvalid/sm_tready  - output-stream handshake (counted as OUT_BEATS)
//   sm_tdata             - output-stream data (captured as LAST_Y)
//   io_out, io_oeb       - checkbits value and pad enables (active low)
module fir_perf_monitor
    import fir_perf_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0100,
    parameter int          CNT_W     = 32
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    fir_perf_monitor_if.slave   wbs,
    input  logic                ap_start,
    input  logic                ap_done,
    input  logic                ss_tvalid,
    input  logic                ss_tready,
    input  logic                sm_tvalid,
    input  logic                sm_tready,
    input  logic [31:0]         sm_tdata,
    output logic [15:0]         io_out,
    output logic [15:0]         io_oeb
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e      state_q;
    logic        ap_start_q, en_q, ovr_q, first_seen_q;
    logic [31:0] last_y_q;
    logic [15:0] io_out_q;
    logic        ack_q;
    logic [31:0] dat_q;

    // ---------------- event decode ----------------
    logic        in_run, start_edge, start_go, done_go, ss_hs, sm_hs;
    logic [31:0] y_fin;

    assign in_run     = (state_q == ST_RUN);
    assign start_edge = en_q & ap_start & ~ap_start_q;
    assign start_go   = start_edge & ~in_run;
    assign done_go    = in_run & ap_done;
    assign ss_hs      = ss_tvalid & ss_tready;
    assign sm_hs      = sm_tvalid & sm_tready;
    // the done marker must reflect a handshake landing on the done cycle
    assign y_fin      = sm_hs ? sm_tdata : last_y_q;

    // ---------------- Wishbone decode ----------------
    logic       wb_sel, wb_acc, wb_wr, wr_ctrl, wr_runs;
    logic [2:0] wb_reg;

    assign wb_sel  = wbs.wbs_cyc_i & wbs.wbs_stb_i &
                     (wbs.wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    // a held strobe only starts a new access once the previous ack has dropped
    assign wb_acc  = wb_sel & ~ack_q;
    assign wb_wr   = wb_acc & wbs.wbs_we_i;
    assign wb_reg  = wbs.wbs_adr_i[4:2];
    assign wr_ctrl = wb_wr & (wb_reg == OFF_CTRL[4:2]) & wbs.wbs_sel_i[0];
    assign wr_runs = wb_wr & (wb_reg == OFF_RUN_CNT[4:2]) & (|wbs.wbs_sel_i);

    logic unused_bits;
    assign unused_bits = ^{wbs.wbs_adr_i[1:0], wbs.wbs_dat_i[31:3], wbs.wbs_dat_i[0],
                           wbs.wbs_sel_i[3:1]};

    // ---------------- counter bank ----------------
    logic [NUM_CNT-1:0]            cnt_clr, cnt_inc;
    logic [NUM_CNT-1:0][CNT_W-1:0] cnt_add, cnt_q;
    logic [CNT_W-1:0]              last_fin;

    // LAST_CYC including the current RUN cycle, saturated
    assign last_fin = (&cnt_q[C_LAST]) ? cnt_q[C_LAST] : cnt_q[C_LAST] + CNT_ONE;

    always_comb begin
        cnt_clr = '0;
        cnt_inc = '0;
        for (int i = 0; i < NUM_CNT; i++) cnt_add[i] = CNT_ONE;

        cnt_clr[C_LAST]  = start_go;
        cnt_inc[C_LAST]  = in_run;

        // cleared at start and fired once, so the add acts as a load of LAST_CYC+1
        cnt_clr[C_FIRST] = start_go;
        cnt_inc[C_FIRST] = in_run & sm_hs & ~first_seen_q;
        cnt_add[C_FIRST] = last_fin;

        cnt_clr[C_IN]    = start_go;
        cnt_inc[C_IN]    = in_run & ss_hs;
        cnt_clr[C_OUT]   = start_go;
        cnt_inc[C_OUT]   = in_run & sm_hs;

        cnt_clr[C_TOTAL] = wr_runs;
        cnt_inc[C_TOTAL] = done_go;
        cnt_add[C_TOTAL] = last_fin;

        cnt_clr[C_RUNS]  = wr_runs;
        cnt_inc[C_RUNS]  = done_go;
    end

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        fir_perf_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk_i (wb_clk_i),
            .rst_i (wb_rst_i),
            .clr_i (cnt_clr[g]),
            .inc_i (cnt_inc[g]),
            .add_i (cnt_add[g]),
            .cnt_o (cnt_q[g])
        );
    end

    // ---------------- run FSM ----------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= ST_IDLE;
            ap_start_q   <= 1'b0;
            en_q         <= 1'b0;
            ovr_q        <= 1'b0;
            first_seen_q <= 1'b0;
            last_y_q     <= '0;
            io_out_q     <= '0;
        end else begin
            ap_start_q <= ap_start;

            if (wr_ctrl) en_q <= wbs.wbs_dat_i[CTRL_EN];

            // a fresh overlap beats a same-cycle W1C so it is never lost
            if (start_edge & in_run)                       ovr_q <= 1'b1;
            else if (wr_ctrl & wbs.wbs_dat_i[CTRL_OVR])    ovr_q <= 1'b0;

            if (in_run & sm_hs) begin
                last_y_q     <= sm_tdata;
                first_seen_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_go) begin
                        state_q      <= ST_RUN;
                        first_seen_q <= 1'b0;
                        io_out_q     <= {8'h00, MARK_START};
                    end
                end
                ST_RUN: begin
                    if (ap_done) begin
                        state_q  <= ST_DONE;
                        io_out_q <= {y_fin[7:0], MARK_DONE};
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // ---------------- Wishbone response ----------------
    logic [31:0] rd_data;

    always_comb begin
        rd_data = '0;
        case (wb_reg)
            3'd0: begin
                rd_data[CTRL_BUSY] = in_run;
                rd_data[CTRL_OVR]  = ovr_q;
                rd_data[CTRL_EN]   = en_q;
            end
            3'd1:    rd_data = 32'(cnt_q[C_LAST]);
            3'd2:    rd_data = 32'(cnt_q[C_TOTAL]);
            3'd3:    rd_data = 32'(cnt_q[C_RUNS]);
            3'd4:    rd_data = 32'(cnt_q[C_FIRST]);
            3'd5:    rd_data = 32'(cnt_q[C_IN]);
            3'd6:    rd_data = 32'(cnt_q[C_OUT]);
            default: rd_data = last_y_q;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= wb_acc;
            dat_q <= (wb_acc & ~wbs.wbs_we_i) ? rd_data : '0;
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign io_out        = io_out_q;
    assign io_oeb        = {16{~en_q}};

endmodule
